err_scan_ctrl: RTL and testbench

//  Sequencer for the parity-error identifier datapath. Loads N_WORDS W-bit code words serially.

---
 rtl/err_scan_if.sv | 31 +++
 rtl/err_scan_ctrl.sv | 109 ++++++++++
 tb/tb_err_scan_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/err_scan_if.sv
// Handshake bundle between a serial word source / fault consumer and err_scan_ctrl.
// The master drives the frame and acknowledges reports; the slave is the scanner.
interface err_scan_if #(
    parameter int N_WORDS = 8,
    parameter int W       = 4
);
    localparam int CW  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int ECW = $clog2(N_WORDS + 1);

    logic           start;
    logic [W-1:0]   d_in;
    logic           d_valid;
    logic           ack;
    logic           busy;
    logic           valid;
    logic [W-1:0]   y;
    logic [CW-1:0]  ch;
    logic           e;
    logic [ECW-1:0] err_cnt;
    logic           done;

    modport master (
        output start, d_in, d_valid, ack,
        input  busy, valid, y, ch, e, err_cnt, done
    );

    modport slave (
        input  start, d_in, d_valid, ack,
        output busy, valid, y, ch, e, err_cnt, done
    );
endinterface

// File: rtl/err_scan_ctrl.sv
// Parity-error scanner: loads a frame of words, flags odd-weight words and reports
// them highest slot first over a valid/ack handshake.
module err_scan_ctrl #(
    parameter int N_WORDS = 8,
    parameter int W       = 4
) (
    input  logic     clk,
    input  logic     rst,
    err_scan_if.slave bus
);
    localparam int CW  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int ECW = $clog2(N_WORDS + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REPORT, S_DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [ECW-1:0]  err_cnt_reg;
    logic [N_WORDS-1:0] err_reg, err_next;
    logic [N_WORDS-1:0] slot_we;
    logic [W-1:0]    mem_reg [N_WORDS];

    logic          frame_start;
    logic          capture;
    logic          last_slot;
    logic          any_err;
    logic          report_valid;
    logic          ack_fire;
    logic [CW-1:0] top_idx;

    assign frame_start  = (state_reg == S_IDLE) && bus.start;
    assign capture      = (state_reg == S_LOAD) && bus.d_valid;
    assign last_slot    = (cnt_reg == CW'(N_WORDS - 1));
    assign any_err      = |err_reg;
    assign report_valid = (state_reg == S_REPORT) && any_err;
    assign ack_fire     = report_valid && bus.ack;

    // Highest flagged slot wins: later iterations override earlier ones.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (err_reg[i]) top_idx = CW'(i);
        end
    end

    // Per-slot write enable and flag update.
    genvar gi;
    generate
        for (gi = 0; gi < N_WORDS; gi++) begin : g_slot
            assign slot_we[gi]  = capture && (cnt_reg == CW'(gi));
            assign err_next[gi] = frame_start                          ? 1'b0 :
                                  slot_we[gi]                          ? ^bus.d_in :
                                  (ack_fire && (top_idx == CW'(gi)))   ? 1'b0 :
                                                                         err_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= '0;
            for (int i = 0; i < N_WORDS; i++) mem_reg[i] <= '0;
        end else begin
            err_reg <= err_next;
            for (int i = 0; i < N_WORDS; i++) begin
                if (slot_we[i]) mem_reg[i] <= bus.d_in;
            end
        end
    end

    // Slot counter saturates at the last slot; the FSM leaves LOAD on that capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            err_cnt_reg <= '0;
        end else if (frame_start) begin
            cnt_reg     <= '0;
            err_cnt_reg <= '0;
        end else if (capture) begin
            err_cnt_reg <= err_cnt_reg + ECW'(^bus.d_in);
            if (!last_slot) cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (bus.start) state_next = S_LOAD;
            S_LOAD:   if (capture && last_slot) state_next = S_REPORT;
            S_REPORT: if (!any_err) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state_reg != S_IDLE);
        bus.valid   = report_valid;
        bus.ch      = report_valid ? top_idx : '0;
        bus.y       = report_valid ? mem_reg[top_idx] : '0;
        bus.e       = any_err;
        bus.err_cnt = err_cnt_reg;
        bus.done    = (state_reg == S_DONE);
    end
endmodule

// File: tb/tb_err_scan_ctrl.sv
// Directed bench for err_scan_ctrl: expected reports are queued as frames are loaded
// and popped as the scanner presents them.
module tb_err_scan_ctrl;
    localparam int N = 8;
    localparam int W = 4;

    typedef logic [W-1:0] word_t;
    typedef struct {
        int ch;
        int y;
    } rep_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    err_scan_if #(.N_WORDS(N), .W(W)) bus ();
    err_scan_ctrl #(.N_WORDS(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    checks   = 0;
    int    failures = 0;
    rep_t  sb[$];
    word_t frame[N];
    int    exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts a frame (with a stray odd word on the START cycle) and shifts in frame[].
    task automatic load_frame(input bit gaps, input bit noise);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.d_valid = 1'b1;
        bus.d_in    = 4'h1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.d_valid = 1'b0;
        chk("busy_load", bus.busy, 1);
        chk("err_cnt_clear", bus.err_cnt, 0);
        exp_cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (gaps && i > 0) begin
                repeat (2) begin
                    bus.d_valid = 1'b0;
                    bus.start   = noise;
                    bus.d_in    = 4'h1;
                    @(negedge clk);
                end
            end
            bus.start   = 1'b0;
            bus.d_valid = 1'b1;
            bus.d_in    = frame[i];
            exp_cnt    += int'(^frame[i]);
            @(negedge clk);
        end
        bus.d_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (^frame[i]) sb.push_back('{i, int'(frame[i])});
        end
        chk("err_cnt", bus.err_cnt, exp_cnt);
    endtask

    // Drains reports; called at the first negedge after the last capture.
    task automatic report(input bit ack_high, input int k);
        int cyc;
        bit phase;
        bit seen_done;
        cyc = 0;
        phase = 1'b0;
        seen_done = 1'b0;
        while (cyc < 40 && !seen_done) begin
            if (bus.done) begin
                seen_done = 1'b1;
                chk("done_valid", bus.valid, 0);
                chk("done_busy", bus.busy, 1);
                chk("sb_empty", sb.size(), 0);
                if (ack_high) chk("done_latency", cyc, k + 1);
                bus.ack   = 1'b0;
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                chk("idle_after_done", bus.busy, 0);
                chk("done_pulse", bus.done, 0);
                chk("err_cnt_hold", bus.err_cnt, k);
            end else begin
                if (bus.valid) begin
                    chk("e_pending", bus.e, 1);
                    if (sb.size() == 0) begin
                        chk("spurious_valid", bus.valid, 0);
                        bus.ack = ack_high;
                    end else begin
                        chk("ch", bus.ch, sb[0].ch);
                        chk("y", bus.y, sb[0].y);
                        if (ack_high || phase) begin
                            bus.ack = 1'b1;
                            void'(sb.pop_front());
                        end else begin
                            bus.ack = 1'b0;
                        end
                        phase = !phase;
                    end
                end else begin
                    chk("ch_zero", bus.ch, 0);
                    chk("y_zero", bus.y, 0);
                    chk("e_clear", bus.e, 0);
                    bus.ack = ack_high;
                end
                cyc++;
                @(negedge clk);
            end
        end
        chk("done_seen", seen_done, 1);
        bus.ack = 1'b0;
        sb.delete();
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.d_in    = '0;
        bus.d_valid = 1'b0;
        bus.ack     = 1'b0;

        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_ch", bus.ch, 0);
        chk("rst_e", bus.e, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        chk("rst_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;

        // All-legal frame
        frame = '{4'h0, 4'h3, 4'hC, 4'h5, 4'hA, 4'h9, 4'h6, 4'hF};
        load_frame(1'b0, 1'b0);
        report(1'b1, 0);

        // Two faults, slow manual ack
        frame = '{4'h0, 4'h3, 4'h1, 4'h5, 4'hA, 4'h9, 4'h6, 4'h7};
        load_frame(1'b0, 1'b0);
        report(1'b0, 2);

        // Same frame, ack held high
        load_frame(1'b0, 1'b0);
        report(1'b1, 2);

        // Gapped load with START noise and ACK high during LOAD
        bus.ack = 1'b1;
        load_frame(1'b1, 1'b1);
        report(1'b0, 2);

        // Reset while CH=7 pending
        load_frame(1'b0, 1'b0);
        chk("pre_rst_valid", bus.valid, 1);
        chk("pre_rst_ch", bus.ch, 7);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_valid", bus.valid, 0);
        chk("mid_rst_y", bus.y, 0);
        chk("mid_rst_ch", bus.ch, 0);
        chk("mid_rst_e", bus.e, 0);
        chk("mid_rst_err_cnt", bus.err_cnt, 0);
        chk("mid_rst_done", bus.done, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        frame = '{4'h0, 4'h3, 4'hC, 4'h5, 4'h8, 4'h9, 4'h6, 4'hF};
        load_frame(1'b0, 1'b0);
        report(1'b1, 1);

        // Every word faulty
        frame = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h7, 4'hB, 4'hD, 4'hE};
        load_frame(1'b0, 1'b0);
        report(1'b1, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
